tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
- Programmable multi-channel tick scheduler built on a free-running prescaler.
- Provides single-cycle enable strobes to game subsystems: physics step, sprite animation, enemy AI, timer countdown.
- Replaces ad-hoc taps on raw divider bits with per-channel periods, configurable at runtime through a write port, plus a global pause.
- Sits between the board clock and the game-logic modules; all consumers stay on clk and use tick[] as clock enables.

Parameters:
NCH, 4, number of tick channels (cfg_ch width fixed at 2 bits; NCH <= 4)
PW, 24, width of channel period and channel counter
PRESCALE, 1000, clk cycles per base tick (>= 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
run  input  1  global run; 0 freezes prescaler and all channel counters
cfg_we  input  1  config write strobe, sampled on rising clk
cfg_ch  input  2  channel index for write
cfg_period  input  PW  period in base ticks; 0 = channel silent
cfg_en  input  1  channel enable value written with period
cfg_ack  output  1  one-cycle pulse, write accepted
base_tick  output  1  one-cycle pulse per prescaler wrap
tick  output  NCH  per-channel one-cycle strobes
active  output  NCH  per-channel enable bits (en[c] && period[c] != 0)

Behaviour:
- Reset (rst=0, async, takes effect immediately):
  - prescaler, all cnt[c], period[c] and en[c] cleared to 0.
  - tick, base_tick, cfg_ack and active all 0.
- Prescaler:
  - pre counts 0..PRESCALE-1 only while run=1.
  - Internal strobe s = run && (pre == PRESCALE-1); pre wraps to 0 on s.
  - base_tick is a registered copy of s: high exactly the cycle after the strobe cycle.
  - PRESCALE=1: s is high every cycle while run=1.
- Channel c, when en[c]=1 and period[c] != 0:
  - On s: if cnt[c] == period[c]-1, cnt[c] <= 0 and tick[c] pulses next cycle; else cnt[c] <= cnt[c]+1.
  - tick[c] is registered, so it is coincident with base_tick.
  - period=1: tick[c] on every base_tick. period=N: every Nth base_tick.
  - First tick after configuration is the Nth strobe after the write cycle.
- Disabled channel (en=0 or period=0): cnt holds at 0, tick[c]=0.
- Multiple channels may tick in the same cycle; no serialisation.
- Config write (cfg_we=1 at a rising edge):
  - period[cfg_ch] <= cfg_period; en[cfg_ch] <= cfg_en; cnt[cfg_ch] <= 0.
  - cfg_ack pulses the following cycle. Writes are accepted every cycle back-to-back, each acked individually.
  - Write to a channel coincident with s: the write wins, that channel produces no tick for that strobe, and its count restarts from 0.
  - Other channels are unaffected by a write.
  - Writes are accepted while run=0.
  - cfg_ch >= NCH: write ignored, cfg_ack still pulses.
- active updates the cycle after a write.
- run=0 mid-period: pre and cnt hold, no base_tick or tick. On run=1, counting resumes from the held values, so the phase is preserved and the interval is stretched by exactly the paused cycles.
- Width rules: cnt and period are PW unsigned bits; maximum period 2^PW-1. Prescaler width = clog2(PRESCALE), minimum 1.

Test Plan:
1. PRESCALE=4. Hold reset, release, run=1, no config -> all outputs 0 during reset; base_tick pulses every 4 cycles, first at cycle 4 after release; tick=0 throughout.
2. Write ch0 period=3 en=1 -> cfg_ack high 1 cycle later; active[0]=1; tick[0] every 12 cycles, coincident with every 3rd base_tick after the write.
3. Same cycle configuration: ch1 period=1 and ch2 period=2 -> tick[1] with every base_tick; tick[2] on alternate base_ticks; tick[1] and tick[2] high together without loss.
4. ch0 period=3; drop run for 20 cycles mid-period -> no base_tick or tick while paused; the next tick[0] interval is exactly 32 cycles, then 12 again.
5. Rewrite ch0 (period=2) on a strobe cycle where tick[0] was due -> no tick[0] for that strobe; next tick[0] on the 2nd following strobe; cfg_ack pulses once.
6. ch3 period=0 en=1 -> active[3]=0, never ticks. Assert rst mid-run with tick pending -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/tick_scheduler.sv
// Multi-channel tick scheduler: a free-running prescaler produces a base strobe,
// and each channel divides it by a runtime-programmable period into tick strobes.
module tick_scheduler #(
   parameter int NCH      = 4,
   parameter int PW       = 24,
   parameter int PRESCALE = 1000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   input  logic           cfg_we,
   input  logic [1:0]     cfg_ch,
   input  logic [PW-1:0]  cfg_period,
   input  logic           cfg_en,
   output logic           cfg_ack,
   output logic           base_tick,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] active
);

   localparam int PREW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PREW-1:0] PRE_LAST = PREW'(PRESCALE - 1);
   localparam logic [PREW-1:0] PRE_ONE  = PREW'(1);
   localparam logic [PW-1:0]   ONE      = PW'(1);
   localparam logic [PW-1:0]   ZERO     = '0;

   logic [PREW-1:0] pre;
   logic            strobe;
   logic [PW-1:0]   cnt    [NCH];
   logic [PW-1:0]   period [NCH];
   logic [NCH-1:0]  en;
   logic [NCH-1:0]  wr_sel;
   logic [NCH-1:0]  live;

   assign strobe = run && (pre == PRE_LAST);
   assign active = live;

   always_comb begin
      wr_sel = '0;
      live   = '0;
      for (int c = 0; c < NCH; c++) begin
         wr_sel[c] = cfg_we && (int'(cfg_ch) == c);
         live[c]   = en[c] && (period[c] != ZERO);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre       <= '0;
         base_tick <= 1'b0;
         cfg_ack   <= 1'b0;
      end else begin
         base_tick <= strobe;
         // out-of-range channel writes are dropped but still acknowledged
         cfg_ack   <= cfg_we;
         if (strobe) begin
            pre <= '0;
         end else if (run) begin
            pre <= pre + PRE_ONE;
         end
      end
   end

   // a write to a channel overrides any strobe in the same cycle and restarts its phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en   <= '0;
         tick <= '0;
         for (int c = 0; c < NCH; c++) begin
            cnt[c]    <= '0;
            period[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            tick[c] <= 1'b0;
            if (wr_sel[c]) begin
               period[c] <= cfg_period;
               en[c]     <= cfg_en;
               cnt[c]    <= '0;
            end else if (!live[c]) begin
               cnt[c] <= '0;
            end else if (strobe) begin
               if (cnt[c] == period[c] - ONE) begin
                  cnt[c]  <= '0;
                  tick[c] <= 1'b1;
               end else begin
                  cnt[c] <= cnt[c] + ONE;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: cycle-level reference model feeding a
// scoreboard, a config-write vector table, and directed timing sequences.
module tb_tick_scheduler;

   localparam int NCH = 4;
   localparam int PW  = 24;
   localparam int PS  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           run;
   logic           cfg_we;
   logic [1:0]     cfg_ch;
   logic [PW-1:0]  cfg_period;
   logic           cfg_en;
   logic           cfg_ack;
   logic           base_tick;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] active;

   tick_scheduler #(.NCH(NCH), .PW(PW), .PRESCALE(PS)) dut (
      .clk(clk), .rst(rst), .run(run), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_period(cfg_period), .cfg_en(cfg_en), .cfg_ack(cfg_ack),
      .base_tick(base_tick), .tick(tick), .active(active)
   );

   always #5 clk = ~clk;

   typedef logic [2*NCH+1:0] obs_t;   // {base_tick, cfg_ack, tick, active}

   typedef struct {
      logic [1:0]     ch;
      logic [PW-1:0]  period;
      logic           en;
      logic [NCH-1:0] exp_active;
   } vec_t;

   obs_t           sb_q[$];
   vec_t           tbl[7];
   int             n_cmp = 0;
   int             n_err = 0;
   int             cyc = 0;
   int             bt_cnt = 0;
   logic [NCH-1:0] tick_or;
   logic [NCH-1:0] stray;

   int             m_pre;
   int unsigned    m_cnt[NCH];
   int unsigned    m_per[NCH];
   bit             m_en[NCH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_pre = 0;
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = 0;
         m_per[c] = 0;
         m_en[c]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit             s;
      logic [NCH-1:0] t_exp;
      logic [NCH-1:0] a_exp;
      s     = run && (m_pre == PS - 1);
      t_exp = '0;
      a_exp = '0;
      for (int c = 0; c < NCH; c++) begin
         if (cfg_we && int'(cfg_ch) == c) begin
            m_per[c] = cfg_period;
            m_en[c]  = cfg_en;
            m_cnt[c] = 0;
         end else if (s && m_en[c] && m_per[c] != 0) begin
            m_cnt[c]++;
            if (m_cnt[c] == m_per[c]) begin
               m_cnt[c] = 0;
               t_exp[c] = 1'b1;
            end
         end
         a_exp[c] = m_en[c] && (m_per[c] != 0);
      end
      if (run) m_pre = s ? 0 : m_pre + 1;
      sb_q.push_back({s, cfg_we, t_exp, a_exp});
   endtask

   task automatic step();
      obs_t e;
      obs_t a;
      @(posedge clk);
      if (rst) model_edge();
      else begin
         model_reset();
         sb_q.push_back('0);
      end
      cyc++;
      #1;
      a = {base_tick, cfg_ack, tick, active};
      e = sb_q.pop_front();
      check("cycle_outputs", a, e);
      if (base_tick) bt_cnt++;
      tick_or = tick_or | tick;
      stray   = stray | (tick & ~{NCH{base_tick}});
   endtask

   task automatic wait_ev(input int sel, input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget && t < 0; i++) begin
         step();
         if (sel < 0 ? base_tick : tick[sel]) t = cyc;
      end
      if (t < 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_event sel=%0d: none within %0d cycles", sel, budget);
      end
   endtask

   task automatic write_cfg(input logic [1:0] ch, input logic [PW-1:0] p, input logic en);
      cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_en = en;
      step();
      cfg_we = 1'b0;
   endtask

   initial begin
      int t1, t2, t3, b0, n_bt, n_t1, n_t2, n_both;
      logic pause_bad;

      tbl[0] = '{2'd0, 24'd5,        1'b1, 4'b0001};
      tbl[1] = '{2'd1, 24'd0,        1'b1, 4'b0001};
      tbl[2] = '{2'd2, 24'd7,        1'b0, 4'b0001};
      tbl[3] = '{2'd3, 24'd1,        1'b1, 4'b1001};
      tbl[4] = '{2'd0, 24'd0,        1'b1, 4'b1000};
      tbl[5] = '{2'd1, 24'hFF_FFFF,  1'b1, 4'b1010};
      tbl[6] = '{2'd3, 24'd1,        1'b0, 4'b0010};

      rst = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_en = 1'b0;
      tick_or = '0; stray = '0;
      model_reset();
      repeat (2) step();
      check("reset_outputs", {cfg_ack, base_tick, tick, active}, 0);

      // back-to-back config writes while paused
      rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cfg_we = 1'b1; cfg_ch = tbl[i].ch; cfg_period = tbl[i].period; cfg_en = tbl[i].en;
         step();
         check("tbl_ack", cfg_ack, 1);
         check("tbl_active", active, tbl[i].exp_active);
         check("tbl_quiet", {base_tick, tick}, 0);
      end
      cfg_we = 1'b0;
      step();
      check("tbl_ack_drop", cfg_ack, 0);
      #2 rst = 1'b0;
      #1 check("async_reset_active", active, 0);
      model_reset();
      sb_q.delete();
      step();

      // prescaler free-run, no channels configured
      rst = 1'b1; run = 1'b1; cyc = 0; bt_cnt = 0; tick_or = '0;
      wait_ev(-1, 10, t1);
      check("first_base_tick", t1, 4);
      wait_ev(-1, 10, t2);
      check("base_tick_period", t2, 8);
      check("no_ticks_unconfigured", tick_or, 0);

      // ch0 period 3
      write_cfg(2'd0, 24'd3, 1'b1);
      check("ch0_ack", cfg_ack, 1);
      check("ch0_active", active, 4'b0001);
      b0 = bt_cnt;
      step();
      check("ch0_ack_single", cfg_ack, 0);
      wait_ev(0, 40, t1);
      check("ch0_first_on_3rd_strobe", bt_cnt - b0, 3);
      check("ch0_with_base", base_tick, 1);
      wait_ev(0, 40, t2);
      check("ch0_interval_a", t2 - t1, 12);
      wait_ev(0, 40, t3);
      check("ch0_interval_b", t3 - t2, 12);

      // ch1 period 1, ch2 period 2
      write_cfg(2'd1, 24'd1, 1'b1);
      write_cfg(2'd2, 24'd2, 1'b1);
      check("ch12_active", active, 4'b0111);
      n_bt = 0; n_t1 = 0; n_t2 = 0; n_both = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         n_bt   += int'(base_tick);
         n_t1   += int'(tick[1]);
         n_t2   += int'(tick[2]);
         n_both += int'(tick[1] && tick[2]);
      end
      check("ch12_base_count", n_bt, 10);
      check("ch1_every_base", n_t1, 10);
      check("ch2_alternate", n_t2, 5);
      check("ch12_together", n_both, 5);

      // pause mid-period
      wait_ev(0, 20, t1);
      repeat (5) step();
      run = 1'b0;
      pause_bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (base_tick || tick != '0) pause_bad = 1'b1;
      end
      check("pause_silent", pause_bad, 0);
      run = 1'b1;
      wait_ev(0, 60, t2);
      check("pause_stretched_interval", t2 - t1, 32);
      wait_ev(0, 40, t3);
      check("post_pause_interval", t3 - t2, 12);

      // rewrite ch0 on the strobe where its tick is due
      repeat (11) step();
      write_cfg(2'd0, 24'd2, 1'b1);
      check("rewrite_on_strobe", base_tick, 1);
      check("rewrite_no_tick", tick[0], 0);
      check("rewrite_ack", cfg_ack, 1);
      step();
      check("rewrite_ack_once", cfg_ack, 0);
      wait_ev(0, 30, t1);
      check("rewrite_next_tick", t1 - t3, 20);

      // ch3 with period 0 stays silent
      tick_or = '0;
      write_cfg(2'd3, 24'd0, 1'b1);
      check("ch3_inactive", active[3], 0);
      repeat (20) step();
      check("ch3_never_ticks", tick_or[3], 0);
      check("ticks_only_with_base", stray, 0);

      // asynchronous reset while a tick is showing
      wait_ev(1, 10, t1);
      check("tick_pending", tick[1], 1);
      #2 rst = 1'b0;
      #1 check("async_reset_all", {cfg_ack, base_tick, tick, active}, 0);
      model_reset();
      sb_q.delete();
      repeat (2) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
